// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: 2^INDEX_BITS lines of four 32-bit words,
// refilled one word per beat from the memory controller on a miss.
module ins_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic [31:0]             fetch_ins_q, fetch_ins_d;
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [1:0]              beat_q, beat_d;

    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES][4];

    logic [INDEX_BITS-1:0]   pc_index;
    logic [TAG_W-1:0]        pc_tag;
    logic [1:0]              pc_off;
    logic [INDEX_BITS-1:0]   fill_index;
    logic                    hit;
    logic                    tag_we;
    logic                    data_we;
    logic                    unused_pc_bits;

    assign pc_index       = fetch_pc[3+INDEX_BITS:4];
    assign pc_tag         = fetch_pc[31:4+INDEX_BITS];
    assign pc_off         = fetch_pc[3:2];
    assign unused_pc_bits = ^fetch_pc[1:0];

    // The line being refilled is remembered through mem_addr, so fetch_pc may change mid-refill.
    assign fill_index = mem_addr_q[3+INDEX_BITS:4];
    assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        fetch_valid_d = fetch_valid_q;
        fetch_ins_d   = fetch_ins_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        beat_d        = beat_q;
        tag_we        = 1'b0;
        data_we       = 1'b0;
        if (ready) begin
            unique case (state_q)
                S_IDLE: begin
                    fetch_valid_d = 1'b0;
                    if (fetch_req) begin
                        if (hit) begin
                            fetch_ins_d   = data_q[pc_index][pc_off];
                            fetch_valid_d = 1'b1;
                            state_d       = S_DONE;
                        end else begin
                            valid_d[pc_index] = 1'b0;
                            tag_we            = 1'b1;
                            mem_addr_d        = {fetch_pc[31:4], 4'b0000};
                            mem_req_d         = 1'b1;
                            beat_d            = 2'd0;
                            state_d           = S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (mem_valid) begin
                        data_we = 1'b1;
                        beat_d  = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            valid_d[fill_index] = 1'b1;
                            mem_req_d           = 1'b0;
                            state_d             = S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    // Swallow the cycle in which fetch is still dropping its request.
                    fetch_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            valid_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_ins_q   <= 32'd0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
            beat_q        <= 2'd0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_ins_q   <= fetch_ins_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            beat_q        <= beat_d;
        end
    end

    // Tag and word storage carry no reset; a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (tag_we && !reset) begin
            tag_q[pc_index] <= pc_tag;
        end
        if (data_we && !reset) begin
            data_q[fill_index][beat_q] <= mem_data;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_ins   = fetch_ins_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
endmodule
